hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have parameter JUMP_HOLD, default 2, meaning total cycles stall_j is high per jump (legal 1..15).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the saturating statistics counters.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  5 each  ID source register numbers.
- id_rs1_used, id_rs2_used  in  1 each  ID instruction reads that source.
- id_jump  in  1  ID instruction is jal, jalr or a taken branch.
- ex_load  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- stall  out  1  load-use hold to the PC and IF/ID registers.
- stall_j  out  1  jump hold to the PC register.
- flush_idex  out  1  insert a bubble into ID/EX.
- flush_ifid  out  1  squash IF/ID contents.
- lu_count  out  CNT_W  number of load-use stalls.
- j_count  out  CNT_W  number of jumps.

Function
REQ-005 lu_hazard SHALL be defined as id_valid & ex_load & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)).
REQ-006 The FSM SHALL have two states, IDLE and J_HOLD, plus a 4-bit down-counter hold_cnt.
REQ-007 In IDLE, stall and flush_idex SHALL equal lu_hazard combinationally (same cycle, single cycle, no state change).
REQ-008 In IDLE with id_jump & id_valid & !lu_hazard, stall_j SHALL be 1 combinationally in that cycle.
REQ-009 In the case of REQ-008 with JUMP_HOLD > 1: next state J_HOLD, hold_cnt <= JUMP_HOLD-1. With JUMP_HOLD == 1: remain in IDLE.
REQ-010 In J_HOLD, stall_j SHALL be 1 and flush_ifid SHALL be 1; hold_cnt decrements each cycle; on hold_cnt == 1, next state is IDLE.
REQ-011 stall_j SHALL therefore be high for exactly JUMP_HOLD consecutive cycles per jump.
REQ-012 In J_HOLD, stall and flush_idex SHALL be 0, and id_jump and lu_hazard SHALL be ignored (ID holds squashed contents).
REQ-013 Simultaneous lu_hazard and id_jump in IDLE: the load-use case SHALL win; stall=1, stall_j=0 that cycle, and the jump is re-evaluated the next cycle.
REQ-014 A jump arriving on the cycle J_HOLD returns to IDLE SHALL be evaluated normally in that IDLE cycle.
REQ-015 lu_count SHALL increment by 1 on each cycle with stall=1.
REQ-016 j_count SHALL increment by 1 on each IDLE->jump acceptance (REQ-008).
REQ-017 Both counters SHALL saturate at all-ones and never wrap.
REQ-018 When id_valid=0, no output SHALL assert from IDLE.

Reset
REQ-019 On a clk edge with rst=1, the block SHALL go to IDLE with hold_cnt=0, lu_count=0 and j_count=0.
REQ-020 While rst=1, all 1-bit outputs SHALL be 0.
REQ-021 Reset asserted mid-J_HOLD SHALL abort the hold immediately; stall_j is 0 in the cycle after reset.

Structure
REQ-022 The FSM state encoding and the register-zero constant SHALL live in a shared package pipeline_pkg.
REQ-023 The saturating counter SHALL be one sub-module, sat_counter, instantiated twice.
REQ-024 All flops SHALL be clocked on clk only; combinational outputs SHALL derive only from current inputs and state.

Verification
REQ-025 Load-use: ex_load=1, ex_rd=5, id_rs2=5, id_rs2_used=1, id_valid=1 -> stall=1 and flush_idex=1 for one cycle; lu_count 0->1.
REQ-026 x0 exemption: ex_load=1, ex_rd=0, id_rs1=0, id_rs1_used=1 -> stall stays 0.
REQ-027 Jump with JUMP_HOLD=2: id_jump=1 -> stall_j high for 2 cycles, flush_ifid high in cycle 2 only; j_count=1; second id_jump during the hold is ignored.
REQ-028 Simultaneous hazard and jump: cycle0 stall=1, stall_j=0; cycle1 (hazard cleared) stall_j=1; j_count=1.
REQ-029 Reset mid-hold: JUMP_HOLD=4, rst=1 in the second hold cycle -> next cycle stall_j=0, state IDLE, counters 0.
REQ-030 Saturation: CNT_W=4 with 17 load-use events -> lu_count=15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared hazard FSM encoding and register-zero constant
package pipeline_pkg;

    typedef enum logic {IDLE, J_HOLD} state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb count_d = (inc_i && !(&count_q)) ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall and multi-cycle jump hold with saturating event counters
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int JUMP_HOLD = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_jump,
    input  logic             ex_load,
    input  logic [4:0]       ex_rd,
    output logic             stall,
    output logic             stall_j,
    output logic             flush_idex,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] lu_count,
    output logic [CNT_W-1:0] j_count
);

    state_e     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic       lu_hazard, idle, jump_acc;

    assign lu_hazard = id_valid && ex_load && (ex_rd != REG_ZERO) &&
                       ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    assign idle      = (state_q == IDLE);
    // load-use wins over a simultaneous jump; the jump is seen again next cycle
    assign jump_acc  = !rst && idle && id_valid && id_jump && !lu_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (idle) begin
            if (jump_acc && JUMP_HOLD > 1) begin
                state_d = J_HOLD;
                hold_d  = 4'(JUMP_HOLD - 1);
            end
        end else begin
            hold_d  = hold_q - 4'd1;
            state_d = (hold_q == 4'd1) ? IDLE : J_HOLD;
        end
    end

    always_comb begin
        stall      = !rst && idle && lu_hazard;
        flush_idex = !rst && idle && lu_hazard;
        stall_j    = jump_acc || (!rst && !idle);
        flush_ifid = !rst && !idle;
    end

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall),
        .count_o (lu_count)
    );

    sat_counter #(.W(CNT_W)) u_j_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (jump_acc),
        .count_o (j_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: two parameterisations driven in lockstep, checked against a cycle-count model
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_jump = 1'b0, ex_load = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;

    logic        st_a, sj_a, fx_a, fi_a, st_b, sj_b, fx_b, fi_b;
    logic [3:0]  lu_a, j_a;
    logic [15:0] lu_b, j_b;

    int n_chk = 0;
    int n_fail = 0;
    bit en = 1'b0;

    int rem [2] = '{0, 0};
    int luc [2] = '{0, 0};
    int jc  [2] = '{0, 0};
    int jh  [2] = '{2, 4};
    int mx  [2] = '{15, 65535};

    always #5 clk = ~clk;

    hazard_unit #(.JUMP_HOLD(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_jump(id_jump),
        .ex_load(ex_load), .ex_rd(ex_rd), .stall(st_a), .stall_j(sj_a),
        .flush_idex(fx_a), .flush_ifid(fi_a), .lu_count(lu_a), .j_count(j_a)
    );

    hazard_unit #(.JUMP_HOLD(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_jump(id_jump),
        .ex_load(ex_load), .ex_rd(ex_rd), .stall(st_b), .stall_j(sj_b),
        .flush_idex(fx_b), .flush_ifid(fi_b), .lu_count(lu_b), .j_count(j_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            bit haz, acc;
            int e_st, e_sj, e_fi;
            int a_st [2], a_sj [2], a_fx [2], a_fi [2], a_lu [2], a_j [2];
            a_st = '{int'(st_a), int'(st_b)};
            a_sj = '{int'(sj_a), int'(sj_b)};
            a_fx = '{int'(fx_a), int'(fx_b)};
            a_fi = '{int'(fi_a), int'(fi_b)};
            a_lu = '{int'(lu_a), int'(lu_b)};
            a_j  = '{int'(j_a),  int'(j_b)};
            haz = id_valid && ex_load && ex_rd != 0 &&
                  ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("lu_count[%0d]", k), a_lu[k], luc[k]);
                chk($sformatf("j_count[%0d]", k), a_j[k], jc[k]);
                acc  = 1'b0;
                e_st = 0;
                e_sj = 0;
                e_fi = 0;
                if (!rst) begin
                    if (rem[k] > 0) begin
                        e_sj = 1;
                        e_fi = 1;
                    end else begin
                        e_st = int'(haz);
                        acc  = id_valid && id_jump && !haz;
                        e_sj = int'(acc);
                    end
                end
                chk($sformatf("stall[%0d]", k), a_st[k], e_st);
                chk($sformatf("flush_idex[%0d]", k), a_fx[k], e_st);
                chk($sformatf("stall_j[%0d]", k), a_sj[k], e_sj);
                chk($sformatf("flush_ifid[%0d]", k), a_fi[k], e_fi);
                if (rst) begin
                    rem[k] = 0;
                    luc[k] = 0;
                    jc[k]  = 0;
                end else begin
                    if (rem[k] > 0) rem[k]--;
                    else if (acc) begin
                        rem[k] = jh[k] - 1;
                        if (jc[k] < mx[k]) jc[k]++;
                    end
                    if (e_st == 1 && luc[k] < mx[k]) luc[k]++;
                end
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic ua, input logic ub, input logic j, input logic ld,
                         input logic [4:0] d);
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_rs1 = a; id_rs2 = b; id_rs1_used = ua; id_rs2_used = ub;
        id_jump = j; ex_load = ld; ex_rd = d;
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        en = 1'b1;
        drive(1, 1, 5, 5, 1, 1, 1, 1, 5);
        chk("rst_stall", int'(st_a), 0);
        chk("rst_stall_j", int'(sj_a), 0);
        chk("rst_lu", int'(lu_a), 0);
        nop();
        // load-use through rs2
        drive(0, 1, 0, 5, 0, 1, 0, 1, 5);
        chk("lu_stall", int'(st_a), 1);
        chk("lu_flush_idex", int'(fx_a), 1);
        nop();
        chk("lu_count_1", int'(lu_a), 1);
        chk("lu_one_cycle", int'(st_a), 0);
        // x0 never hazards
        drive(0, 1, 0, 0, 1, 0, 0, 1, 0);
        chk("x0_stall", int'(st_a), 0);
        // jump, second jump ignored during hold
        drive(0, 1, 0, 0, 0, 0, 1, 0, 0);
        chk("j_c1_stall_j", int'(sj_a), 1);
        chk("j_c1_flush_ifid", int'(fi_a), 0);
        drive(0, 1, 0, 0, 0, 0, 1, 0, 0);
        chk("j_c2_stall_j", int'(sj_a), 1);
        chk("j_c2_flush_ifid", int'(fi_a), 1);
        nop();
        chk("j_c3_stall_j", int'(sj_a), 0);
        chk("j_count_1", int'(j_a), 1);
        repeat (4) nop();
        // hazard and jump together
        drive(0, 1, 5, 0, 1, 0, 1, 1, 5);
        chk("hj_stall", int'(st_a), 1);
        chk("hj_stall_j", int'(sj_a), 0);
        drive(0, 1, 5, 0, 1, 0, 1, 0, 0);
        chk("hj_retry_stall_j", int'(sj_a), 1);
        nop();
        chk("hj_j_count", int'(j_a), 2);
        repeat (4) nop();
        // reset in the second hold cycle of the JUMP_HOLD=4 instance
        drive(0, 1, 0, 0, 0, 0, 1, 0, 0);
        chk("rh_c1_stall_j", int'(sj_b), 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rh_rst_stall_j", int'(sj_b), 0);
        nop();
        chk("rh_after_stall_j", int'(sj_b), 0);
        chk("rh_after_j_count", int'(j_b), 0);
        chk("rh_after_lu_count", int'(lu_b), 0);
        // saturation of the 4-bit counter
        repeat (17) drive(0, 1, 7, 0, 1, 0, 0, 1, 7);
        nop();
        chk("sat_lu_a", int'(lu_a), 15);
        chk("sat_lu_b", int'(lu_b), 17);
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)));
        end
        nop();
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
